// File: rtl/extend_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | extend_pipe : registered sign/zero extender with a 2-entry output FIFO   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  a_i,
  input  logic             sext_i,
  input  logic [1:0]       mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_neg_o,
  output logic [1:0]       count_o
);

  localparam logic [1:0] c_MODE_BYTE  = 2'b00;
  localparam logic [1:0] c_MODE_HALF  = 2'b01;
  localparam logic [1:0] c_MODE_FULL  = 2'b10;
  localparam logic [1:0] c_MODE_SHIFT = 2'b11;
  localparam logic [1:0] c_DEPTH      = 2'd2;

  logic [OUT_W-1:0] mem_q [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  logic             w_fill;
  logic [OUT_W-1:0] w_full;
  logic [OUT_W-1:0] w_ext;
  logic             w_push;
  logic             w_pop;

  // Shift mode reuses the full-width extension; the two bits lost at the top
  // are fill copies, so nothing significant is dropped.
  always_comb begin
    w_fill = sext_i & a_i[IN_W-1];
    w_full = {{(OUT_W-IN_W){w_fill}}, a_i};
    w_ext  = '0;
    case (mode_i)
      c_MODE_BYTE: w_ext = {{(OUT_W-8){sext_i & a_i[7]}}, a_i[7:0]};
      c_MODE_HALF: w_ext = {{(OUT_W-16){sext_i & a_i[15]}}, a_i[15:0]};
      c_MODE_FULL: w_ext = w_full;
      c_MODE_SHIFT: w_ext = w_full << 2;
      default:     w_ext = '0;
    endcase
  end

  assign in_ready_o  = (count_q < c_DEPTH);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[head_q];
  assign out_neg_o   = mem_q[head_q][OUT_W-1];
  assign count_o     = count_q;

  assign w_push = in_valid_i & in_ready_o;
  assign w_pop  = out_valid_o & out_ready_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (w_push) tail_d = ~tail_q;
    if (w_pop)  head_d = ~head_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (w_push) mem_q[tail_q] <= w_ext;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_extend_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_extend_pipe : directed vector bench for extend_pipe (IN_W=16,OUT_W=32)|
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_extend_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  a;
  logic             sext;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_neg;
  logic [1:0]       count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic        sext;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .sext_i     (sext),
    .mode_i     (mode),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_neg_o  (out_neg),
    .count_o    (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{16'h8000, 1'b1, 2'b01, 32'hFFFF8000};
    vecs[1]  = '{16'h8000, 1'b0, 2'b01, 32'h00008000};
    vecs[2]  = '{16'h0000, 1'b1, 2'b01, 32'h00000000};
    vecs[3]  = '{16'h1280, 1'b1, 2'b00, 32'hFFFFFF80};
    vecs[4]  = '{16'h1280, 1'b0, 2'b00, 32'h00000080};
    vecs[5]  = '{16'hFFFF, 1'b1, 2'b11, 32'hFFFFFFFC};
    vecs[6]  = '{16'hFFFF, 1'b0, 2'b11, 32'h0003FFFC};
    vecs[7]  = '{16'hFFFF, 1'b0, 2'b10, 32'h0000FFFF};
    vecs[8]  = '{16'h8001, 1'b1, 2'b10, 32'hFFFF8001};
    vecs[9]  = '{16'h8000, 1'b1, 2'b11, 32'hFFFE0000};
    vecs[10] = '{16'hFF7F, 1'b1, 2'b00, 32'h0000007F};
    vecs[11] = '{16'h7FFF, 1'b1, 2'b01, 32'h00007FFF};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; sext = 1'b0; mode = 2'b00; out_ready = 1'b1;
    #12;
    check("rst_count", {30'd0, count}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_neg", {31'd0, out_neg}, 32'd0);

    // Release away from an edge, then apply the table one operand at a time.
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = vecs[i].a; sext = vecs[i].sext; mode = vecs[i].mode;
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      check($sformatf("vec%0d_neg", i), {31'd0, out_neg}, {31'd0, vecs[i].exp[31]});
      tick();
      check($sformatf("vec%0d_drain", i), {30'd0, count}, 32'd0);
    end

    // Backpressure: three back-to-back operands with the consumer stalled.
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; mode = 2'b10; sext = 1'b0; a = 16'h0001;
    tick();
    check("bp_count1", {30'd0, count}, 32'd1);
    @(negedge clk); a = 16'h0002;
    tick();
    check("bp_count2", {30'd0, count}, 32'd2);
    check("bp_in_ready0", {31'd0, in_ready}, 32'd0);
    @(negedge clk); a = 16'h0003;
    tick();
    check("bp_hold_count", {30'd0, count}, 32'd2);
    check("bp_head1", out_data, 32'd1);
    @(negedge clk); out_ready = 1'b1;
    tick();
    check("bp_head2", out_data, 32'd2);
    check("bp_count_after_pop", {30'd0, count}, 32'd1);
    check("bp_in_ready1", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_head3", out_data, 32'd3);
    check("bp_count_pushpop", {30'd0, count}, 32'd1);
    @(negedge clk); in_valid = 1'b0;
    tick();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Streaming at full rate.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'h0100 + 16'(i * 16'h0011);
      tick();
      check($sformatf("st%0d_data", i), out_data, {16'd0, 16'h0100 + 16'(i * 16'h0011)});
      check($sformatf("st%0d_count", i), {30'd0, count}, 32'd1);
      check($sformatf("st%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    @(negedge clk); in_valid = 1'b0;
    tick();

    // Asynchronous reset with the buffer full.
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; a = 16'h0055;
    tick();
    @(negedge clk); a = 16'h00AA;
    tick();
    check("ar_full", {30'd0, count}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_count", {30'd0, count}, 32'd0);
    check("ar_out_data", out_data, 32'd0);
    check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("ar_ignored", {30'd0, count}, 32'd0);
    @(negedge clk); rst_n = 1'b1; a = 16'h1234;
    tick();
    in_valid = 1'b0;
    check("ar_new_valid", {31'd0, out_valid}, 32'd1);
    check("ar_new_data", out_data, 32'h00001234);
    check("ar_new_count", {30'd0, count}, 32'd1);
    @(negedge clk); out_ready = 1'b1;
    tick();
    check("ar_drained", {31'd0, out_valid}, 32'd0);
    tick();
    check("ar_no_stale", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
